nn_weight_loader: RTL and testbench
===================================

Name: nn_weight_loader

Overview:
- Host-side configuration transmitter for the neuron array.
- Accepts a framed word stream from the AXI-Lite/stream bridge through a valid/ready interface.
- Drives the broadcast weight/bias load bus that every neuron decodes: weightValid, weightValue, biasValid, biasValue, config_layer_num, config_neuron_num.
- Sequences one load frame per target neuron and reports completion and framing errors.

Parameters:
- DATA_WIDTH, 16: weight and bias word width (equals `dataWidth).
- CFG_WIDTH, 33: width of the config_layer_num and config_neuron_num buses (2*DATA_WIDTH+1).
- NUM_WEIGHT, 128: maximum weights per neuron; larger frame counts are rejected.
- IN_WIDTH, 32: width of the host stream word.

Ports:
- clk, input, 1: single clock domain.
- rst, input, 1: reset, synchronous, active-low.
- s_data, input, IN_WIDTH: host word.
- s_valid, input, 1: host word valid.
- s_ready, output, 1: block accepts s_data this cycle.
- weightValid, output, 1: one-cycle pulse per weight.
- weightValue, output, DATA_WIDTH: weight word.
- biasValid, output, 1: one-cycle bias pulse.
- biasValue, output, DATA_WIDTH: bias word.
- config_layer_num, output, CFG_WIDTH: target layer, zero-extended.
- config_neuron_num, output, CFG_WIDTH: target neuron, zero-extended.
- busy, output, 1: frame in progress.
- done, output, 1: one-cycle pulse at frame completion.
- err, output, 1: sticky framing error.

Behaviour:
- Frame format:
  - Header word: bit31 = has_bias; [30:24] = layer; [23:16] = neuron; [15:0] = cnt.
  - Then cnt weight words; weight = s_data[DATA_WIDTH-1:0], upper bits ignored.
  - Then one bias word if has_bias = 1.
- Reset (rst = 0 at a clk edge) drives every output to its reset value:
  - weightValid, biasValid, done, busy, err = 0.
  - weightValue, biasValue = 0.
  - config_layer_num, config_neuron_num = all ones, so no neuron 0/0 matches while idle.
  - s_ready = 0 during reset, 1 in the first cycle after it.
- A handshake occurs when s_valid & s_ready. All bus outputs are registered: each pulse appears exactly 1 cycle after its accepting handshake.
- FSM states: IDLE, WGT, BIAS, FIN.
  - IDLE, s_ready = 1. On a header handshake:
    - cnt > NUM_WEIGHT: set err, discard the header, stay in IDLE.
    - Otherwise latch layer, neuron, cnt and has_bias, and drive the config buses next cycle.
    - cnt > 0: go to WGT.
    - cnt = 0 and has_bias = 1: go to BIAS.
    - cnt = 0 and has_bias = 0: go to FIN.
  - WGT, s_ready = 1.
    - Each handshake pulses weightValid with weightValue = the word and decrements the remaining count.
    - On the last word: go to BIAS if has_bias, else FIN.
    - Idle cycles (s_valid = 0) produce no pulse; config buses stay stable.
  - BIAS, s_ready = 1. The handshake pulses biasValid with biasValue = the word; go to FIN.
  - FIN, s_ready = 0, lasting 1 cycle:
    - Pulse done.
    - Config buses return to all ones in the same cycle, after the final valid pulse has been sampled with the target number still applied.
    - Go to IDLE.
- Config bus hold rule: config buses hold the target from the cycle of the first pulse through the cycle of the last pulse, which is a superset of every valid pulse. They change only on the header-accept edge and the FIN edge.
- busy = 1 in WGT, BIAS and FIN, and 0 otherwise.
- weightValid and biasValid are never high in the same cycle. Throughput is one word per clock.
- err clears only on reset. An error does not block later well-formed frames.
- Reset mid-frame: the partial frame is abandoned and no done pulse is issued. The neuron write pointers are not rewound by this block; the system resets the neurons together with the loader.
- biasValid is not address-qualified at the neuron. This block still holds the target config buses during the bias pulse, so address-decoding consumers load correctly.

Test Plan:
- Reset, then header 0x8203_0003 followed by 0x11, 0x22, 0x33, bias 0x44:
  - Three weightValid pulses with values 0x0011, 0x0022, 0x0033 on consecutive cycles.
  - Then biasValid with 0x0044.
  - config_layer_num = 2 and config_neuron_num = 3 throughout.
  - done 1 cycle after the bias pulse; config buses then read all ones.
- Header 0x0100_0080 then 128 words with a gap every 7th cycle:
  - Exactly 128 pulses, none in gap cycles, in order, with no bias.
  - done after the 128th pulse.
- Header with cnt = 0x0081:
  - err = 1, no pulses, stays IDLE.
  - A following valid frame 0x0000_0001 plus one word loads normally; err stays 1.
- Header 0x8000_0000:
  - No weightValid; the next word produces a single biasValid.
  - done after it.
- Header 0x0000_0000: done pulses 2 cycles after the header, with no other activity.
- rst = 0 after 2 of 5 weights:
  - All outputs take their reset values on the next edge, with no done.
  - Config buses read all ones.
  - After release, a fresh frame loads correctly.

Source files
------------

// File: rtl/nn_weight_loader.sv
// Host-side weight/bias loader: parses framed words from the stream bridge and
// drives the broadcast neuron load bus, one frame per target neuron.
module nn_weight_loader #(
   parameter int DATA_WIDTH = 16,
   parameter int CFG_WIDTH  = 33,
   parameter int NUM_WEIGHT = 128,
   parameter int IN_WIDTH   = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [IN_WIDTH-1:0]   s_data,
   input  logic                  s_valid,
   output logic                  s_ready,
   output logic                  weightValid,
   output logic [DATA_WIDTH-1:0] weightValue,
   output logic                  biasValid,
   output logic [DATA_WIDTH-1:0] biasValue,
   output logic [CFG_WIDTH-1:0]  config_layer_num,
   output logic [CFG_WIDTH-1:0]  config_neuron_num,
   output logic                  busy,
   output logic                  done,
   output logic                  err
);

   localparam int CNT_W = $clog2(NUM_WEIGHT + 1);

   typedef enum logic [1:0] {
      IDLE,
      WGT,
      BIAS,
      FIN
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] remaining;
   logic             has_bias;

   logic             handshake;
   logic             hdr_bias;
   logic [6:0]       hdr_layer;
   logic [7:0]       hdr_neuron;
   logic [15:0]      hdr_cnt;
   logic             hdr_too_big;

   assign handshake   = s_valid & s_ready;
   assign hdr_bias    = s_data[31];
   assign hdr_layer   = s_data[30:24];
   assign hdr_neuron  = s_data[23:16];
   assign hdr_cnt     = s_data[15:0];
   assign hdr_too_big = hdr_cnt > 16'(NUM_WEIGHT);

   // NOTE: every register here is assigned with <= so that all of them sample
   // the same pre-edge values; blocking assignments would leak new values
   // into later statements of the same edge.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state             <= IDLE;
         remaining         <= '0;
         has_bias          <= 1'b0;
         s_ready           <= 1'b0;
         weightValid       <= 1'b0;
         weightValue       <= '0;
         biasValid         <= 1'b0;
         biasValue         <= '0;
         config_layer_num  <= '1;
         config_neuron_num <= '1;
         busy              <= 1'b0;
         done              <= 1'b0;
         err               <= 1'b0;
      end else begin
         weightValid <= 1'b0;
         biasValid   <= 1'b0;
         done        <= 1'b0;

         case (state)
            IDLE: begin
               s_ready <= 1'b1;
               if (handshake) begin
                  if (hdr_too_big) begin
                     err <= 1'b1;
                  end else begin
                     config_layer_num  <= CFG_WIDTH'(hdr_layer);
                     config_neuron_num <= CFG_WIDTH'(hdr_neuron);
                     has_bias          <= hdr_bias;
                     remaining         <= CNT_W'(hdr_cnt);
                     busy              <= 1'b1;
                     if (hdr_cnt != 16'd0) begin
                        state <= WGT;
                     end else if (hdr_bias) begin
                        state <= BIAS;
                     end else begin
                        state   <= FIN;
                        s_ready <= 1'b0;
                     end
                  end
               end
            end

            WGT: begin
               if (handshake) begin
                  weightValid <= 1'b1;
                  weightValue <= s_data[DATA_WIDTH-1:0];
                  remaining   <= remaining - CNT_W'(1);
                  if (remaining == CNT_W'(1)) begin
                     if (has_bias) begin
                        state <= BIAS;
                     end else begin
                        state   <= FIN;
                        s_ready <= 1'b0;
                     end
                  end
               end
            end

            BIAS: begin
               if (handshake) begin
                  biasValid <= 1'b1;
                  biasValue <= s_data[DATA_WIDTH-1:0];
                  state     <= FIN;
                  s_ready   <= 1'b0;
               end
            end

            FIN: begin
               // The last valid pulse is on the bus this cycle with the target
               // still applied; the release of the config buses lands after it.
               done              <= 1'b1;
               busy              <= 1'b0;
               config_layer_num  <= '1;
               config_neuron_num <= '1;
               s_ready           <= 1'b1;
               state             <= IDLE;
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_nn_weight_loader.sv
// Directed self-checking bench for nn_weight_loader: each step drives inputs,
// advances one clock and compares outputs against hand-computed values.
module tb_nn_weight_loader;

   localparam int DATA_WIDTH = 16;
   localparam int CFG_WIDTH  = 33;
   localparam int NUM_WEIGHT = 128;
   localparam int IN_WIDTH   = 32;

   localparam logic [63:0] CFG_ONES = 64'h1_FFFF_FFFF;

   logic                  clk;
   logic                  rst;
   logic [IN_WIDTH-1:0]   s_data;
   logic                  s_valid;
   logic                  s_ready;
   logic                  weightValid;
   logic [DATA_WIDTH-1:0] weightValue;
   logic                  biasValid;
   logic [DATA_WIDTH-1:0] biasValue;
   logic [CFG_WIDTH-1:0]  config_layer_num;
   logic [CFG_WIDTH-1:0]  config_neuron_num;
   logic                  busy;
   logic                  done;
   logic                  err;

   int compared   = 0;
   int mismatched = 0;

   nn_weight_loader #(
      .DATA_WIDTH(DATA_WIDTH),
      .CFG_WIDTH (CFG_WIDTH),
      .NUM_WEIGHT(NUM_WEIGHT),
      .IN_WIDTH  (IN_WIDTH)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .s_data           (s_data),
      .s_valid          (s_valid),
      .s_ready          (s_ready),
      .weightValid      (weightValid),
      .weightValue      (weightValue),
      .biasValid        (biasValid),
      .biasValue        (biasValue),
      .config_layer_num (config_layer_num),
      .config_neuron_num(config_neuron_num),
      .busy             (busy),
      .done             (done),
      .err              (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one edge and let outputs settle before sampling.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_state(input string pfx);
      check({pfx, "_s_ready"}, 64'(s_ready), 64'd0);
      check({pfx, "_wvalid"}, 64'(weightValid), 64'd0);
      check({pfx, "_wvalue"}, 64'(weightValue), 64'd0);
      check({pfx, "_bvalid"}, 64'(biasValid), 64'd0);
      check({pfx, "_bvalue"}, 64'(biasValue), 64'd0);
      check({pfx, "_layer"}, 64'(config_layer_num), CFG_ONES);
      check({pfx, "_neuron"}, 64'(config_neuron_num), CFG_ONES);
      check({pfx, "_busy"}, 64'(busy), 64'd0);
      check({pfx, "_done"}, 64'(done), 64'd0);
      check({pfx, "_err"}, 64'(err), 64'd0);
   endtask

   initial begin
      int sent;
      int pulses;
      int cyc;
      logic gap;
      logic [15:0] wexp;

      rst     = 1'b0;
      s_valid = 1'b0;
      s_data  = '0;

      // Reset state
      step();
      step();
      check_reset_state("rst");
      rst = 1'b1;
      step();
      check("rel_s_ready", 64'(s_ready), 64'd1);
      check("rel_busy", 64'(busy), 64'd0);

      // Frame with three weights and a bias, layer 2 neuron 3
      s_valid = 1'b1;
      s_data  = 32'h8203_0003;
      step();
      check("f1_hdr_layer", 64'(config_layer_num), 64'd2);
      check("f1_hdr_neuron", 64'(config_neuron_num), 64'd3);
      check("f1_hdr_busy", 64'(busy), 64'd1);
      check("f1_hdr_wvalid", 64'(weightValid), 64'd0);
      s_data = 32'h0000_0011;
      step();
      check("f1_w0_valid", 64'(weightValid), 64'd1);
      check("f1_w0_value", 64'(weightValue), 64'h0011);
      s_data = 32'h0000_0022;
      step();
      check("f1_w1_valid", 64'(weightValid), 64'd1);
      check("f1_w1_value", 64'(weightValue), 64'h0022);
      check("f1_w1_layer", 64'(config_layer_num), 64'd2);
      s_data = 32'h0000_0033;
      step();
      check("f1_w2_valid", 64'(weightValid), 64'd1);
      check("f1_w2_value", 64'(weightValue), 64'h0033);
      check("f1_w2_bvalid", 64'(biasValid), 64'd0);
      s_data = 32'h0000_0044;
      step();
      check("f1_b_valid", 64'(biasValid), 64'd1);
      check("f1_b_value", 64'(biasValue), 64'h0044);
      check("f1_b_wvalid", 64'(weightValid), 64'd0);
      check("f1_b_layer", 64'(config_layer_num), 64'd2);
      check("f1_b_neuron", 64'(config_neuron_num), 64'd3);
      check("f1_b_done", 64'(done), 64'd0);
      check("f1_fin_s_ready", 64'(s_ready), 64'd0);
      s_valid = 1'b0;
      step();
      check("f1_done", 64'(done), 64'd1);
      check("f1_done_bvalid", 64'(biasValid), 64'd0);
      check("f1_done_layer", 64'(config_layer_num), CFG_ONES);
      check("f1_done_neuron", 64'(config_neuron_num), CFG_ONES);
      check("f1_done_busy", 64'(busy), 64'd0);
      check("f1_done_s_ready", 64'(s_ready), 64'd1);
      step();
      check("f1_done_clear", 64'(done), 64'd0);

      // Full 128-weight frame with a bubble every 7th cycle, layer 1 neuron 0
      s_valid = 1'b1;
      s_data  = 32'h0100_0080;
      step();
      check("f2_hdr_layer", 64'(config_layer_num), 64'd1);
      check("f2_hdr_neuron", 64'(config_neuron_num), 64'd0);
      sent   = 0;
      pulses = 0;
      cyc    = 0;
      while (sent < NUM_WEIGHT) begin
         gap  = (cyc % 7) == 6;
         wexp = 16'(sent * 3 + 5);
         s_valid = !gap;
         s_data  = {16'hDEAD, wexp};
         step();
         if (weightValid) pulses++;
         check("f2_wvalid", 64'(weightValid), 64'(!gap));
         check("f2_bvalid", 64'(biasValid), 64'd0);
         if (!gap) begin
            check("f2_wvalue", 64'(weightValue), 64'(wexp));
            sent++;
         end
         cyc++;
      end
      check("f2_layer_last", 64'(config_layer_num), 64'd1);
      check("f2_fin_s_ready", 64'(s_ready), 64'd0);
      check("f2_no_done_yet", 64'(done), 64'd0);
      s_valid = 1'b0;
      step();
      check("f2_pulses", 64'(pulses), 64'd128);
      check("f2_done", 64'(done), 64'd1);
      check("f2_done_wvalid", 64'(weightValid), 64'd0);
      check("f2_done_bvalid", 64'(biasValid), 64'd0);
      check("f2_done_layer", 64'(config_layer_num), CFG_ONES);

      // Oversized count is rejected, later frame still loads
      s_valid = 1'b1;
      s_data  = 32'h0000_0081;
      step();
      check("f3_err", 64'(err), 64'd1);
      check("f3_busy", 64'(busy), 64'd0);
      check("f3_wvalid", 64'(weightValid), 64'd0);
      check("f3_layer", 64'(config_layer_num), CFG_ONES);
      check("f3_s_ready", 64'(s_ready), 64'd1);
      s_data = 32'h0000_0001;
      step();
      check("f3b_hdr_busy", 64'(busy), 64'd1);
      check("f3b_hdr_layer", 64'(config_layer_num), 64'd0);
      check("f3b_hdr_neuron", 64'(config_neuron_num), 64'd0);
      s_data = 32'h0000_BEEF;
      step();
      check("f3b_wvalid", 64'(weightValid), 64'd1);
      check("f3b_wvalue", 64'(weightValue), 64'hBEEF);
      check("f3b_err_sticky", 64'(err), 64'd1);
      s_valid = 1'b0;
      step();
      check("f3b_done", 64'(done), 64'd1);
      check("f3b_err_hold", 64'(err), 64'd1);

      // Bias-only frame
      s_valid = 1'b1;
      s_data  = 32'h8000_0000;
      step();
      check("f4_hdr_busy", 64'(busy), 64'd1);
      check("f4_hdr_wvalid", 64'(weightValid), 64'd0);
      check("f4_hdr_s_ready", 64'(s_ready), 64'd1);
      s_data = 32'h1234_5678;
      step();
      check("f4_bvalid", 64'(biasValid), 64'd1);
      check("f4_bvalue", 64'(biasValue), 64'h5678);
      check("f4_wvalid", 64'(weightValid), 64'd0);
      s_valid = 1'b0;
      step();
      check("f4_done", 64'(done), 64'd1);
      check("f4_done_bvalid", 64'(biasValid), 64'd0);

      // Empty frame: done two cycles after the header cycle
      s_valid = 1'b1;
      s_data  = 32'h0000_0000;
      step();
      check("f5_hdr_busy", 64'(busy), 64'd1);
      check("f5_hdr_done", 64'(done), 64'd0);
      check("f5_hdr_s_ready", 64'(s_ready), 64'd0);
      s_valid = 1'b0;
      step();
      check("f5_done", 64'(done), 64'd1);
      check("f5_wvalid", 64'(weightValid), 64'd0);
      check("f5_bvalid", 64'(biasValid), 64'd0);
      check("f5_layer", 64'(config_layer_num), CFG_ONES);

      // Reset after two of five weights, then a fresh frame
      s_valid = 1'b1;
      s_data  = 32'h0305_0005;
      step();
      check("f6_hdr_layer", 64'(config_layer_num), 64'd3);
      s_data = 32'h0000_0101;
      step();
      s_data = 32'h0000_0202;
      step();
      check("f6_w1_value", 64'(weightValue), 64'h0202);
      rst    = 1'b0;
      s_data = 32'h0000_0303;
      step();
      check_reset_state("f6_rst");
      rst     = 1'b1;
      s_valid = 1'b0;
      step();
      check("f6_rel_s_ready", 64'(s_ready), 64'd1);
      check("f6_rel_done", 64'(done), 64'd0);
      s_valid = 1'b1;
      s_data  = 32'h8407_0001;
      step();
      check("f7_hdr_layer", 64'(config_layer_num), 64'd4);
      check("f7_hdr_neuron", 64'(config_neuron_num), 64'd7);
      s_data = 32'h0000_00AA;
      step();
      check("f7_wvalid", 64'(weightValid), 64'd1);
      check("f7_wvalue", 64'(weightValue), 64'h00AA);
      s_data = 32'h0000_00BB;
      step();
      check("f7_bvalid", 64'(biasValid), 64'd1);
      check("f7_bvalue", 64'(biasValue), 64'h00BB);
      check("f7_b_neuron", 64'(config_neuron_num), 64'd7);
      s_valid = 1'b0;
      step();
      check("f7_done", 64'(done), 64'd1);
      check("f7_err", 64'(err), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
